// File: rtl/if_id_fetch_queue.sv
// IF/ID boundary queue: DEPTH-entry circular buffer of {pc4, instruction} pairs.
// Fetch fills it while decode stalls. An empty queue presents a NOP and the retained pc4.
// All state changes on the falling clock edge.
module if_id_fetch_queue #(
  parameter int unsigned NB    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_step,
  input  logic                   i_flush,
  input  logic                   i_stall,
  input  logic                   i_push,
  input  logic [NB-1:0]          i_pc4,
  input  logic [NB-1:0]          i_instruction,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_valid,
  output logic [NB-1:0]          o_pc4,
  output logic [NB-1:0]          o_instruction
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [NB-1:0] pc4;
    logic [NB-1:0] instr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [NB-1:0] hold_pc4_q, hold_pc4_d;
  logic          full, valid, push, pop;
  entry_t        head;

  // Status comes from the count register alone; push and pop qualify against it.
  assign full  = (count_q == CW'(DEPTH));
  assign valid = (count_q != '0);
  assign pop   = i_step & ~i_stall & valid;
  assign push  = i_step & i_push & (~full | pop);
  assign head  = mem_q[rd_ptr_q];

  // Next-state logic for the pointers, the count and the retained pc4.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    hold_pc4_d = hold_pc4_q;
    if (i_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      hold_pc4_d = i_pc4;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + PW'(1);
        hold_pc4_d = head.pc4;
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control state register, with asynchronous clear.
  always_ff @(negedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_pc4_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_pc4_q <= hold_pc4_d;
    end
  end

  // Entry storage. It has no reset because slots are only read while they are valid.
  always_ff @(negedge i_clk) begin
    if (i_reset && !i_flush && push) begin
      mem_q[wr_ptr_q] <= {i_pc4, i_instruction};
    end
  end

  // The head is presented when occupied; otherwise a NOP with the retained pc4.
  assign o_count       = count_q;
  assign o_full        = full;
  assign o_empty       = ~valid;
  assign o_valid       = valid;
  assign o_pc4         = valid ? head.pc4 : hold_pc4_q;
  assign o_instruction = valid ? head.instr : '0;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Bench for if_id_fetch_queue. A queue-based reference model is compared on every rising edge.
// Directed literal checks pin the model at each scenario.
module tb_if_id_fetch_queue;

  localparam int unsigned NB    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          step, flush, stall, push;
  logic [NB-1:0] pc4, instr;
  logic          full, empty, valid;
  logic [2:0]    count;
  logic [NB-1:0] o_pc4, o_instr;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  typedef struct packed {
    logic [NB-1:0] pc4;
    logic [NB-1:0] ins;
  } ent_t;

  ent_t          mq[$];
  logic [NB-1:0] m_hold;

  if_id_fetch_queue #(.NB(NB), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_step       (step),
    .i_flush      (flush),
    .i_stall      (stall),
    .i_push       (push),
    .i_pc4        (pc4),
    .i_instruction(instr),
    .o_full       (full),
    .o_empty      (empty),
    .o_count      (count),
    .o_valid      (valid),
    .o_pc4        (o_pc4),
    .o_instruction(o_instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO queue with the falling-edge update rules.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_hold = '0;
    end else if (flush) begin
      mq.delete();
      m_hold = pc4;
    end else begin
      bit do_pop, do_push;
      do_pop  = step && !stall && (mq.size() > 0);
      do_push = step && push && ((mq.size() < DEPTH) || do_pop);
      if (do_pop) begin
        m_hold = mq[0].pc4;
        void'(mq.pop_front());
      end
      if (do_push) mq.push_back({pc4, instr});
    end
  end

  // Compare process: every output against the model, away from the active edge.
  always @(posedge clk) begin
    if (started) begin
      int sz;
      sz = mq.size();
      chk("cyc_count", NB'(count), NB'(sz));
      chk("cyc_valid", NB'(valid), NB'(sz > 0));
      chk("cyc_empty", NB'(empty), NB'(sz == 0));
      chk("cyc_full",  NB'(full),  NB'(sz == DEPTH));
      chk("cyc_instr", o_instr, (sz > 0) ? mq[0].ins : '0);
      chk("cyc_pc4",   o_pc4,   (sz > 0) ? mq[0].pc4 : m_hold);
    end
  end

  // One active (falling) edge; returns just after the following rising edge.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [2:0] c, input logic v,
                     input logic [NB-1:0] ins, input logic [NB-1:0] p);
    chk({nm, "_count"}, NB'(count), NB'(c));
    chk({nm, "_valid"}, NB'(valid), NB'(v));
    chk({nm, "_instr"}, o_instr, ins);
    chk({nm, "_pc4"},   o_pc4,   p);
  endtask

  initial begin
    rst_n = 1'b0; step = 1'b0; flush = 1'b0; stall = 1'b0; push = 1'b0;
    pc4 = '0; instr = '0;
    #2;
    lit("por", 3'd0, 1'b0, 32'h0, 32'h0);
    chk("por_empty", NB'(empty), 32'd1);
    chk("por_full",  NB'(full),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    started = 1'b1;

    // Fill three entries under stall, then reset asynchronously mid-run.
    step = 1'b1; stall = 1'b1; push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr = 32'h100 + 32'(i); pc4 = 32'h200 + 32'(4 * i);
      tick();
    end
    lit("pre_rst", 3'd3, 1'b1, 32'h100, 32'h200);
    rst_n = 1'b0;
    #1;
    lit("async_rst", 3'd0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill to full under stall, then a dropped fifth push.
    for (int i = 1; i <= 4; i++) begin
      instr = 32'h11 * 32'(i); pc4 = 32'(4 * i);
      tick();
    end
    lit("full4", 3'd4, 1'b1, 32'h11, 32'd4);
    chk("full4_flag", NB'(full), 32'd1);
    instr = 32'h99; pc4 = 32'd20;
    tick();
    lit("drop5", 3'd4, 1'b1, 32'h11, 32'd4);

    // Full queue, pop plus push each edge; 0x55 wraps around behind 0x44.
    stall = 1'b0; instr = 32'h55; pc4 = 32'h54;
    tick(); lit("walk1", 3'd4, 1'b1, 32'h22, 32'd8);
    tick(); lit("walk2", 3'd4, 1'b1, 32'h33, 32'd12);
    tick(); lit("walk3", 3'd4, 1'b1, 32'h44, 32'd16);
    tick(); lit("walk4", 3'd4, 1'b1, 32'h55, 32'h54);

    // Drain to two entries, then flush with a push that must be ignored.
    push = 1'b0;
    tick(); tick();
    lit("cnt2", 3'd2, 1'b1, 32'h55, 32'h54);
    flush = 1'b1; push = 1'b1; pc4 = 32'h40; instr = 32'hDEAD;
    tick();
    flush = 1'b0; push = 1'b0;
    lit("flush", 3'd0, 1'b0, 32'h0, 32'h40);

    // One entry, then step low for five edges, then step high.
    stall = 1'b1; push = 1'b1; instr = 32'h66; pc4 = 32'h64;
    tick();
    lit("one", 3'd1, 1'b1, 32'h66, 32'h64);
    step = 1'b0; stall = 1'b0; instr = 32'h77; pc4 = 32'h74;
    for (int i = 0; i < 5; i++) begin
      tick();
      lit("nostep", 3'd1, 1'b1, 32'h66, 32'h64);
    end
    step = 1'b1;
    tick();
    lit("step_pp", 3'd1, 1'b1, 32'h77, 32'h74);
    push = 1'b0;
    tick();
    lit("step_drain", 3'd0, 1'b0, 32'h0, 32'h74);

    // Single push into an empty queue: visible after one edge, popped at the next.
    push = 1'b1; instr = 32'hAB; pc4 = 32'h8;
    tick();
    lit("single_vis", 3'd1, 1'b1, 32'hAB, 32'h8);
    push = 1'b0; pc4 = 32'h0;
    tick();
    lit("single_pop", 3'd0, 1'b0, 32'h0, 32'h8);
    chk("single_empty", NB'(empty), 32'd1);

    tick();
    started = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
